// File: rtl/vga_pattern_gen.sv
// Test-pattern colour generator placed between vga_sync and the board pins.
// Four selectable patterns, pausable frame counter, 2-stage registered output with matched sync delay.
module vga_pattern_gen #(
  parameter int BPC        = 2,
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 10,
  parameter int FRAME_BITS = 8,
  parameter int TILE_SHIFT = 4,
  parameter int BAR_SHIFT  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [H_BITS-1:0]     h,
  input  logic [V_BITS-1:0]     v,
  input  logic                  visible,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [1:0]            mode,
  input  logic                  pause,
  output logic [BPC-1:0]        red,
  output logic [BPC-1:0]        green,
  output logic [BPC-1:0]        blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic [FRAME_BITS-1:0] frame
);

  // Zero-extended width wide enough that every pattern bit index is in range;
  // bits above the real input width therefore read as 0.
  localparam int XW = H_BITS + V_BITS + FRAME_BITS + TILE_SHIFT + BAR_SHIFT + BPC + 4;

  logic                  vsync_prev_r;
  logic [1:0]            active_mode_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic                  vsync_rise_s;

  logic [BPC-1:0] s1_red_r, s1_green_r, s1_blue_r;
  logic           s1_hsync_r, s1_vsync_r;
  logic [BPC-1:0] red_r, green_r, blue_r;
  logic           hsync_r, vsync_r;

  logic [H_BITS-1:0] h2_s;
  logic [V_BITS-1:0] v2_s;
  logic [XW-1:0]     hx_s, vx_s, fx_s, h2x_s, v2x_s;
  logic              m_red_s, m_green_s, m_blue_s, boost_s;
  logic [2:0]        bar_s;
  logic [BPC-1:0]    pat_red_s, pat_green_s, pat_blue_s;

  // Shimmer channel: MSB is the checker bit, lower bits add the boost highlight.
  function automatic logic [BPC-1:0] shimmer(input logic m, input logic boost);
    logic [BPC-1:0] res;
    res          = {BPC{m & boost}};
    res[BPC-1]   = m;
    return res;
  endfunction

  assign vsync_rise_s = vsync_in & ~vsync_prev_r;

  assign h2_s  = h + H_BITS'(frame_r[4:1]);
  assign v2_s  = v + V_BITS'(frame_r[5:2]);
  assign hx_s  = XW'(h);
  assign vx_s  = XW'(v);
  assign fx_s  = XW'(frame_r);
  assign h2x_s = XW'(h2_s);
  assign v2x_s = XW'(v2_s);

  assign m_red_s   = hx_s[TILE_SHIFT]     ^ vx_s[TILE_SHIFT];
  assign m_green_s = hx_s[TILE_SHIFT + 1] ^ vx_s[TILE_SHIFT + 1];
  assign m_blue_s  = hx_s[TILE_SHIFT + 2] ^ vx_s[TILE_SHIFT + 2];
  assign boost_s   = h2x_s[TILE_SHIFT - 1] ^ v2x_s[TILE_SHIFT - 1];
  assign bar_s     = 3'(hx_s >> BAR_SHIFT);

  // Pattern selection for the current pixel, blanked outside the active area.
  always_comb begin
    pat_red_s   = {BPC{1'b0}};
    pat_green_s = {BPC{1'b0}};
    pat_blue_s  = {BPC{1'b0}};
    if (visible) begin
      case (active_mode_r)
        2'd0: begin
          pat_red_s   = {BPC{m_red_s}};
          pat_green_s = {BPC{m_green_s}};
          pat_blue_s  = {BPC{m_blue_s}};
        end
        2'd1: begin
          pat_red_s   = shimmer(m_red_s, boost_s);
          pat_green_s = shimmer(m_green_s, boost_s);
          pat_blue_s  = shimmer(m_blue_s, boost_s);
        end
        2'd2: begin
          pat_red_s   = {BPC{bar_s[0]}};
          pat_green_s = {BPC{bar_s[1]}};
          pat_blue_s  = {BPC{bar_s[2]}};
        end
        2'd3: begin
          pat_red_s   = BPC'(hx_s >> TILE_SHIFT);
          pat_green_s = BPC'(vx_s >> TILE_SHIFT);
          pat_blue_s  = BPC'(fx_s);
        end
        default: begin
          pat_red_s   = {BPC{1'b0}};
          pat_green_s = {BPC{1'b0}};
          pat_blue_s  = {BPC{1'b0}};
        end
      endcase
    end else begin
      pat_red_s   = {BPC{1'b0}};
      pat_green_s = {BPC{1'b0}};
      pat_blue_s  = {BPC{1'b0}};
    end
  end

  // Frame bookkeeping: counter and pattern latch only move on a vsync rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_r  <= 1'b0;
      active_mode_r <= 2'd0;
      frame_r       <= {FRAME_BITS{1'b0}};
    end else begin
      vsync_prev_r <= vsync_in;
      if (vsync_rise_s) begin
        active_mode_r <= mode;
        if (!pause) begin
          frame_r <= frame_r + FRAME_BITS'(1);
        end else begin
          frame_r <= frame_r;
        end
      end else begin
        active_mode_r <= active_mode_r;
        frame_r       <= frame_r;
      end
    end
  end

  // Two-stage output pipeline; sync travels alongside colour so both land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_red_r   <= {BPC{1'b0}};
      s1_green_r <= {BPC{1'b0}};
      s1_blue_r  <= {BPC{1'b0}};
      s1_hsync_r <= 1'b0;
      s1_vsync_r <= 1'b0;
      red_r      <= {BPC{1'b0}};
      green_r    <= {BPC{1'b0}};
      blue_r     <= {BPC{1'b0}};
      hsync_r    <= 1'b0;
      vsync_r    <= 1'b0;
    end else begin
      s1_red_r   <= pat_red_s;
      s1_green_r <= pat_green_s;
      s1_blue_r  <= pat_blue_s;
      s1_hsync_r <= hsync_in;
      s1_vsync_r <= vsync_in;
      red_r      <= s1_red_r;
      green_r    <= s1_green_r;
      blue_r     <= s1_blue_r;
      hsync_r    <= s1_hsync_r;
      vsync_r    <= s1_vsync_r;
    end
  end

  assign red   = red_r;
  assign green = green_r;
  assign blue  = blue_r;
  assign hsync = hsync_r;
  assign vsync = vsync_r;
  assign frame = frame_r;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen at default parameters (BPC=2, T=4, bars at 64 px).
// Expected pixels are queued as inputs are driven and compared when they emerge two cycles later.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h, v;
  logic       visible, hsync_in, vsync_in, pause;
  logic [1:0] mode;
  logic [1:0] red, green, blue;
  logic       hsync, vsync;
  logic [7:0] frame;

  vga_pattern_gen dut (
    .clk(clk), .reset(reset), .h(h), .v(v), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .pause(pause),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .frame(frame)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  string      phase    = "init";
  logic [7:0] exp_q[$];
  logic [7:0] m_frame  = 8'd0;
  logic [1:0] m_mode   = 2'd0;
  logic       m_vprev  = 1'b0;
  logic [1:0] cur_mode = 2'd0;
  logic       cur_pause = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference pattern with the default parameters written out bit by bit.
  function automatic logic [7:0] model_out(input logic [9:0] hh, input logic [9:0] vv,
      input logic vis, input logic hs, input logic vs, input logic [1:0] md, input logic [7:0] fr);
    logic [1:0] r, g, b;
    logic [9:0] h2, v2;
    logic mr, mg, mb, bo;
    mr = hh[4] ^ vv[4];
    mg = hh[5] ^ vv[5];
    mb = hh[6] ^ vv[6];
    h2 = hh + {6'd0, fr[4:1]};
    v2 = vv + {6'd0, fr[5:2]};
    bo = h2[3] ^ v2[3];
    case (md)
      2'd0: begin r = {mr, mr}; g = {mg, mg}; b = {mb, mb}; end
      2'd1: begin r = {mr, mr & bo}; g = {mg, mg & bo}; b = {mb, mb & bo}; end
      2'd2: begin r = {hh[6], hh[6]}; g = {hh[7], hh[7]}; b = {hh[8], hh[8]}; end
      default: begin r = hh[5:4]; g = vv[5:4]; b = fr[1:0]; end
    endcase
    if (!vis) begin r = 2'd0; g = 2'd0; b = 2'd0; end
    return {r, g, b, hs, vs};
  endfunction

  task automatic step(input logic rst, input logic [9:0] hh, input logic [9:0] vv,
      input logic vis, input logic hs, input logic vs);
    logic rise;
    reset = rst; h = hh; v = vv; visible = vis; hsync_in = hs; vsync_in = vs;
    mode = cur_mode; pause = cur_pause;
    rise = vs & ~m_vprev;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(8'd0);
      exp_q.push_back(8'd0);
      m_frame = 8'd0; m_mode = 2'd0; m_vprev = 1'b0;
    end else begin
      exp_q.push_back(model_out(hh, vv, vis, hs, vs, m_mode, m_frame));
      m_vprev = vs;
      if (rise) begin
        m_mode = cur_mode;
        if (!cur_pause) m_frame = m_frame + 8'd1;
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) check_val(phase, {red, green, blue, hsync, vsync}, exp_q.pop_front());
    check_val({phase, "_frame"}, frame, m_frame);
  endtask

  task automatic pix(input logic [9:0] hh, input logic [9:0] vv, input logic vis);
    step(1'b0, hh, vv, vis, 1'($urandom_range(1, 0)), 1'b0);
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++)
      pix(10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)), 1'($urandom_range(3, 0) != 0));
  endtask

  task automatic pulse();
    step(1'b0, 10'($urandom_range(1023, 0)), 10'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 10'($urandom_range(1023, 0)), 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)), 1'b1,
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
  endtask

  initial begin
    phase = "reset";
    do_reset(3);

    phase = "mode0";
    pix(10'd16, 10'd0, 1'b1);
    pix(10'd16, 10'd16, 1'b1);
    pix(10'd16, 10'd0, 1'b0);
    pix(10'd32, 10'd0, 1'b1);
    pix(10'd64, 10'd0, 1'b1);
    rand_pix(20);

    phase = "mode_latency";
    cur_mode = 2'd2;
    rand_pix(10);
    pulse();
    pix(10'd64, 10'd0, 1'b1);
    pix(10'd448, 10'd0, 1'b1);
    pix(10'd128, 10'd5, 1'b1);
    rand_pix(10);

    phase = "frame_count";
    cur_mode = 2'd0;
    do_reset(1);
    for (int i = 0; i < 5; i++) pulse();
    check_val("frame5", frame, 8'd5);
    cur_pause = 1'b1;
    for (int i = 0; i < 3; i++) pulse();
    check_val("frame_paused", frame, 8'd5);
    cur_pause = 1'b0;
    do_reset(1);
    for (int i = 0; i < 256; i++) pulse();
    check_val("frame_wrap", frame, 8'd0);

    phase = "mode1";
    cur_mode = 2'd1;
    do_reset(1);
    pulse();
    pulse();
    check_val("frame2", frame, 8'd2);
    pix(10'd7, 10'd0, 1'b1);
    pix(10'd23, 10'd0, 1'b1);
    pix(10'd24, 10'd0, 1'b1);
    rand_pix(30);
    for (int i = 0; i < 6; i++) begin pulse(); rand_pix(8); end

    phase = "mode3";
    cur_mode = 2'd3;
    pulse();
    rand_pix(30);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cur_mode  = 2'($urandom_range(3, 0));
      cur_pause = 1'($urandom_range(3, 0) == 0);
      if ($urandom_range(99, 0) == 0)
        do_reset(1);
      else
        step(1'b0, 10'($urandom_range(1023, 0)), 10'($urandom_range(1023, 0)),
             1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    phase = "reset_mid";
    do_reset(2);
    cur_mode = 2'd2;
    pix(10'd448, 10'd0, 1'b1);
    pix(10'd448, 10'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
